// File: rtl/ndm_reset_sequencer.sv
// ---------------------------------------------------------------------------
// ndm_reset_sequencer
//
// Turns the debug module's ndmreset level into ordered, minimum-width,
// active-low resets. The peripheral subsystem is released first and the core
// last. A debug request seen during the reset window is held pending, so the
// core halts on its first fetch after a debug-initiated reset.
//
// Build option:
//   NDM_RESET_SEQ_SYNC_EN - when defined, each input passes through a 2-flop
//                           synchronizer instead of a single register stage.
//                           Input-to-decision latency grows by one cycle.
//
// Parameter legality: PERIPH_HOLD_CYCLES and CORE_RELEASE_DELAY must lie in
// 1 .. 2**CNT_WIDTH-1.
// ---------------------------------------------------------------------------
module ndm_reset_sequencer #(
    parameter int PERIPH_HOLD_CYCLES = 16,
    parameter int CORE_RELEASE_DELAY = 8,
    parameter int CNT_WIDTH          = 8
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic ndmreset,
    input  logic debug_req_irq,
    output logic periph_aresetn,
    output logic core_aresetn,
    output logic core_debug_req,
    output logic seq_busy
);

    typedef enum logic [1:0] {
        ST_ASSERT     = 2'd0,
        ST_REL_PERIPH = 2'd1,
        ST_IDLE       = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(PERIPH_HOLD_CYCLES) - CNT_ONE;
    localparam logic [CNT_WIDTH-1:0] CORE_LOAD = CNT_WIDTH'(CORE_RELEASE_DELAY) - CNT_ONE;

    // Input stage outputs: every control decision is taken on these only.
    logic ndm_q_r;
    logic dbg_q_r;

    state_t                 state_r;
    state_t                 state_s;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic [CNT_WIDTH-1:0]   cnt_s;
    logic                   pending_r;
    logic                   pending_s;

    logic                   periph_aresetn_r;
    logic                   core_aresetn_r;
    logic                   core_debug_req_r;
    logic                   seq_busy_r;
    logic                   periph_aresetn_s;
    logic                   core_aresetn_s;
    logic                   core_debug_req_s;
    logic                   seq_busy_s;

`ifdef NDM_RESET_SEQ_SYNC_EN
    logic ndm_meta_r;
    logic dbg_meta_r;

    // Two-flop synchronizers: inputs may arrive from an unrelated clock domain.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ndm_meta_r <= 1'b0;
            dbg_meta_r <= 1'b0;
            ndm_q_r    <= 1'b0;
            dbg_q_r    <= 1'b0;
        end else begin
            ndm_meta_r <= ndmreset;
            dbg_meta_r <= debug_req_irq;
            ndm_q_r    <= ndm_meta_r;
            dbg_q_r    <= dbg_meta_r;
        end
    end
`else
    // Single register stage on both debug module outputs.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ndm_q_r <= 1'b0;
            dbg_q_r <= 1'b0;
        end else begin
            ndm_q_r <= ndmreset;
            dbg_q_r <= debug_req_irq;
        end
    end
`endif

    // Next-state and hold/delay counter: a retrigger always wins over release.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_ASSERT: begin
                if ((cnt_r == CNT_ZERO) && !ndm_q_r) begin
                    state_s = ST_REL_PERIPH;
                    cnt_s   = CORE_LOAD;
                end else if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else begin
                    // Hold time met but ndmreset still high: stay, count saturated.
                    cnt_s = CNT_ZERO;
                end
            end
            ST_REL_PERIPH: begin
                if (ndm_q_r) begin
                    state_s = ST_ASSERT;
                    cnt_s   = HOLD_LOAD;
                end else if (cnt_r == CNT_ZERO) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (ndm_q_r) begin
                    state_s = ST_ASSERT;
                    cnt_s   = HOLD_LOAD;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                // Unreachable encoding: recover through a full reset sequence.
                state_s = ST_ASSERT;
                cnt_s   = HOLD_LOAD;
            end
        endcase
    end

    // Pending halt: set anywhere inside the sequence, cleared once idle and the request drops.
    always_comb begin
        pending_s = pending_r;
        if (state_r == ST_IDLE) begin
            if (!dbg_q_r) begin
                pending_s = 1'b0;
            end else begin
                pending_s = pending_r;
            end
        end else begin
            if (dbg_q_r) begin
                pending_s = 1'b1;
            end else begin
                pending_s = pending_r;
            end
        end
    end

    // Output values follow the state being entered, so they register alongside it.
    always_comb begin
        periph_aresetn_s = (state_s != ST_ASSERT);
        core_aresetn_s   = (state_s == ST_IDLE);
        seq_busy_s       = (state_s != ST_IDLE);
        if (state_s == ST_ASSERT) begin
            // Never hand a halt request to a core that is held in reset.
            core_debug_req_s = 1'b0;
        end else begin
            core_debug_req_s = dbg_q_r | pending_s;
        end
    end

    // State, counter, pending flag and registered outputs.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r          <= ST_ASSERT;
            cnt_r            <= HOLD_LOAD;
            pending_r        <= 1'b0;
            periph_aresetn_r <= 1'b0;
            core_aresetn_r   <= 1'b0;
            core_debug_req_r <= 1'b0;
            seq_busy_r       <= 1'b1;
        end else begin
            state_r          <= state_s;
            cnt_r            <= cnt_s;
            pending_r        <= pending_s;
            periph_aresetn_r <= periph_aresetn_s;
            core_aresetn_r   <= core_aresetn_s;
            core_debug_req_r <= core_debug_req_s;
            seq_busy_r       <= seq_busy_s;
        end
    end

    assign periph_aresetn = periph_aresetn_r;
    assign core_aresetn   = core_aresetn_r;
    assign core_debug_req = core_debug_req_r;
    assign seq_busy       = seq_busy_r;

endmodule

// File: doc/ndm_reset_sequencer.md
Name: ndm_reset_sequencer

Overview:
- Sits directly downstream of the debug module wrapper.
- Consumes its ndmreset (active-high) and debug_req_irq outputs.
- Produces ordered, minimum-width, active-low resets for the peripheral subsystem and the Ariane core, released peripherals first, core last.
- Holds a debug request pending across the reset window so the core halts on its first fetch after a debug-initiated reset.

Parameters:
- PERIPH_HOLD_CYCLES, 16: minimum number of cycles both resets stay asserted once a sequence starts. Legal range 1..2^CNT_WIDTH-1.
- CORE_RELEASE_DELAY, 8: cycles between peripheral reset release and core reset release. Legal range 1..2^CNT_WIDTH-1.
- CNT_WIDTH, 8: width of the shared down-counter.

Ports:
- aclk  input  1  system clock
- aresetn  input  1  synchronous active-low reset
- ndmreset  input  1  non-debug-module reset request from the debug module, active-high, level
- debug_req_irq  input  1  halt request from the debug module, level
- periph_aresetn  output  1  peripheral reset, active-low, registered
- core_aresetn  output  1  core reset, active-low, registered
- core_debug_req  output  1  debug request to the core, registered
- seq_busy  output  1  high whenever state != IDLE

Behaviour:
Interface:
- One clock, aclk. Reset aresetn is synchronous and active-low. All state changes only on rising edge of aclk.

Input stage:
- ndmreset and debug_req_irq pass through one register stage, giving ndm_q and dbg_q.
- All control decisions use ndm_q and dbg_q only.

Reset values (aresetn low at an edge):
- state = ASSERT, cnt = PERIPH_HOLD_CYCLES-1, pending = 0.
- periph_aresetn = 0, core_aresetn = 0, core_debug_req = 0, seq_busy = 1.
- When aresetn releases, a full power-on sequence runs.

FSM (outputs registered alongside the state update):
- ASSERT:
  - periph_aresetn = 0, core_aresetn = 0.
  - cnt decrements, saturating at 0.
  - When cnt == 0 and ndm_q == 0: go to REL_PERIPH, cnt = CORE_RELEASE_DELAY-1.
  - ndm_q held high keeps the block in ASSERT indefinitely.
- REL_PERIPH:
  - periph_aresetn = 1, core_aresetn = 0.
  - cnt decrements; when cnt == 0, go to IDLE.
- IDLE:
  - Both resets high.
  - When ndm_q == 1: go to ASSERT, cnt = PERIPH_HOLD_CYCLES-1.

Timing:
- Latency from ndmreset rising (sampled at edge k) to reset outputs low: edge k+1.
- Release: periph_aresetn rises exactly PERIPH_HOLD_CYCLES cycles after ASSERT entry, or on the cycle after ndm_q falls, whichever is later. core_aresetn rises exactly CORE_RELEASE_DELAY cycles after periph_aresetn.

Re-trigger:
- ndm_q high in REL_PERIPH: return to ASSERT next edge, periph_aresetn re-asserted, cnt reloaded to PERIPH_HOLD_CYCLES-1.
- ndm_q high in the same cycle the REL_PERIPH→IDLE transition would occur: ASSERT wins, and core_aresetn stays 0.

Debug request:
- pending is set when dbg_q == 1 and state != IDLE.
- pending is cleared in IDLE on any cycle with dbg_q == 0.
- core_debug_req = dbg_q | pending, registered.
- core_debug_req is forced to 0 while state == ASSERT, so no request reaches the core during reset.
- Consequence: a request seen during the sequence is presented no later than the cycle core_aresetn rises, and holds at least 1 cycle.
- Simultaneous set and clear is impossible, since set requires non-IDLE and clear requires IDLE.

Optional Feature:
- Macro: NDM_RESET_SEQ_SYNC_EN.
- Defined: the input stage is a 2-flop synchronizer per input; debug_req_irq and ndmreset may come from an asynchronous domain. Input-to-decision latency grows by 1 cycle, so ndmreset to reset assertion is k+2. All other timing is unchanged. Synchronizer flops reset to 0.
- Undefined: single register stage as above.

Test Plan:
- Power-on: aresetn low 3 cycles then high, inputs 0 → periph_aresetn rises 16 cycles after aresetn release; core_aresetn rises 8 cycles later; seq_busy drops with core_aresetn.
- Short ndmreset pulse: 1-cycle ndmreset in IDLE → resets low at k+1; periph release at ASSERT entry+16; core release +8.
- Long ndmreset: high for 40 cycles → periph_aresetn released 1 cycle after ndm_q falls; core 8 cycles later; no early release at count 0.
- Re-trigger in REL_PERIPH: ndmreset pulse 3 cycles after periph release → periph_aresetn re-asserted next edge; core_aresetn never rises; full 16+8 sequence restarts.
- Halt across reset: debug_req_irq high at ASSERT entry, low 5 cycles later → core_debug_req 0 during ASSERT, 1 from REL_PERIPH entry through the core_aresetn rising cycle, cleared the next IDLE cycle.
- aresetn mid-sequence: aresetn low during REL_PERIPH → next edge both resets 0, pending 0, cnt = 15; a full sequence reruns after release. With NDM_RESET_SEQ_SYNC_EN defined, repeat the short-pulse test → assertion at k+2.
